// File: rtl/axi_pkg.sv
// Shared AXI4 constants, read-initiator state type and the 4 KB burst-split helper.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ADDR,
    RD_DATA
  } rd_state_e;

  // Beats of size 'bytes' that fit between addr and the next 4 KB boundary (1..4096/bytes).
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr, input int unsigned bytes);
    int unsigned room;
    room = 32'd4096 - {20'd0, addr};
    return 13'(room / bytes);
  endfunction

endpackage

// File: rtl/axi_rd_master.sv
// AXI4 read-burst initiator: one request in flight, split into INCR bursts at 4 KB
// boundaries, returned beats re-registered onto a no-backpressure rd_* stream.
module axi_rd_master
  import axi_pkg::*;
#(
  parameter int         AXI_ADDR_WIDTH = 32,
  parameter int         AXI_DATA_WIDTH = 64,
  parameter logic [3:0] AXI_ID         = 4'd0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]                req_len,
  output logic                      rd_valid,
  output logic [AXI_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_last,
  output logic                      rd_err,
  output logic                      ar_valid,
  input  logic                      ar_ready,
  output logic [AXI_ADDR_WIDTH-1:0] ar_addr,
  output logic [3:0]                ar_id,
  output logic [7:0]                ar_len,
  output logic [2:0]                ar_size,
  output logic [1:0]                ar_burst,
  input  logic                      r_valid,
  output logic                      r_ready,
  input  logic [AXI_DATA_WIDTH-1:0] r_data,
  input  logic [1:0]                r_resp,
  input  logic                      r_last
);

  localparam int                        BYTES    = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_INC = AXI_ADDR_WIDTH'(BYTES);

  rd_state_e                 state, state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] cur_addr;
  logic [8:0]                remain, bcnt;
  logic                      err, err_nxt;
  logic                      req_fire, ar_fire, r_fire;
  logic                      burst_end, final_beat, enter_addr;
  logic [AXI_ADDR_WIDTH-1:0] burst_addr;
  logic [8:0]                burst_remain, burst_beats;
  logic [12:0]               bound;

  assign ar_id    = AXI_ID;
  assign ar_size  = 3'($clog2(BYTES));
  assign ar_burst = AXI_BURST_INCR;

  assign req_fire   = req_valid & req_ready;
  assign ar_fire    = ar_valid & ar_ready;
  assign r_fire     = r_valid & r_ready;
  assign burst_end  = (bcnt == 9'd1);
  assign final_beat = (remain == 9'd1);
  assign enter_addr = req_fire | (r_fire & burst_end & ~final_beat);

  // bcnt decides where a burst ends; r_last only contributes to the error flag.
  assign err_nxt = err | (r_resp != AXI_RESP_OKAY) | (r_last != burst_end);

  // Address/remaining count as they will be once the transition into ADDR lands,
  // so the burst registers are valid in the first ADDR cycle.
  always_comb begin
    burst_addr   = cur_addr + ADDR_INC;
    burst_remain = remain - 9'd1;
    if (state == RD_IDLE) begin
      burst_addr   = req_addr;
      burst_remain = {1'b0, req_len} + 9'd1;
    end
    bound       = beats_to_4k(burst_addr[11:0], BYTES);
    burst_beats = ({4'd0, burst_remain} <= bound) ? burst_remain : bound[8:0];
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    case (state)
      RD_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = RD_ADDR;
      end
      RD_ADDR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        r_ready = 1'b1;
        if (r_valid && burst_end) state_nxt = final_beat ? RD_IDLE : RD_ADDR;
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RD_IDLE;
      cur_addr <= '0;
      remain   <= '0;
      bcnt     <= '0;
      err      <= 1'b0;
      ar_addr  <= '0;
      ar_len   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rd_valid <= r_fire;
      rd_last  <= r_fire & final_beat;
      rd_err   <= r_fire & final_beat & err_nxt;
      if (r_fire) rd_data <= r_data;
      if (req_fire) begin
        cur_addr <= req_addr;
        remain   <= {1'b0, req_len} + 9'd1;
        err      <= 1'b0;
      end
      if (enter_addr) begin
        ar_addr <= burst_addr;
        ar_len  <= 8'(burst_beats - 9'd1);
      end
      if (ar_fire) bcnt <= {1'b0, ar_len} + 9'd1;
      if (r_fire) begin
        remain   <= remain - 9'd1;
        bcnt     <= bcnt - 9'd1;
        cur_addr <= cur_addr + ADDR_INC;
        err      <= err_nxt;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_master.sv
// Randomized bench for axi_rd_master: behavioural slave with stall/error injection and
// a request-level model predicting the AR bursts and the returned beat stream.
module tb_axi_rd_master;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        rd_valid, rd_last, rd_err;
  logic [63:0] rd_data;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic [3:0]  ar_id;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready, r_last;
  logic [63:0] r_data;
  logic [1:0]  r_resp;

  axi_rd_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_err(rd_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [63:0] data; logic last; logic err; } beat_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;

  beat_t exp_rd[$];
  ar_t   exp_ar[$];
  int    vectors = 0, miscompares = 0;
  int    rx_cnt = 0;
  int    ar_stall = 0, err_beat = -1, badlast_beat = -1, sl_beat = 0;
  int    sl_left = 0;
  logic [31:0] sl_addr = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Slave + output monitor; all decisions at negedge, handshakes land on the next posedge.
  initial begin
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0; sl_left = 0;
        continue;
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_extra", 64'(exp_rd.size()), 64'd1);
        else begin
          beat_t b;
          b = exp_rd.pop_front();
          chk("rd_data", rd_data, b.data);
          chk("rd_last", 64'(rd_last), 64'(b.last));
          chk("rd_err", 64'(rd_err), 64'(b.err));
          if (b.last) chk("idle_at_last", 64'(req_ready), 64'd1);
        end
        rx_cnt++;
      end
      r_valid = 1'b0; r_last = 1'b0; r_resp = 2'b00;
      if (sl_left > 0 && r_ready && $urandom_range(0, 3) != 0) begin
        r_valid = 1'b1;
        r_data  = mem_word(sl_addr);
        r_resp  = (sl_beat == err_beat) ? 2'b10 : 2'b00;
        r_last  = (sl_left == 1) ^ (sl_beat == badlast_beat);
        sl_addr = sl_addr + 32'd8;
        sl_left--;
        sl_beat++;
      end
      ar_ready = 1'b0;
      if (ar_valid) begin
        if (exp_ar.size() == 0) chk("ar_extra", 64'(exp_ar.size()), 64'd1);
        else begin
          chk("ar_addr", ar_addr, exp_ar[0].addr);
          chk("ar_len", 64'(ar_len), 64'(exp_ar[0].len));
        end
        chk("ar_size", 64'(ar_size), 64'd3);
        chk("ar_burst", 64'(ar_burst), 64'd1);
        chk("ar_id", 64'(ar_id), 64'd0);
        chk("r_ready_in_addr", 64'(r_ready), 64'd0);
        if (ar_stall > 0) ar_stall--;
        else begin
          ar_ready = 1'b1;
          sl_addr  = ar_addr;
          sl_left  = int'(ar_len) + 1;
          if (exp_ar.size() != 0) void'(exp_ar.pop_front());
        end
      end
    end
  end

  // One request: predict bursts/beats from the 4 KB rule, issue it, wait for the stream.
  task automatic run_req(input logic [31:0] addr, input int len, input int stall,
                         input int eb, input int bl, input bit abort);
    logic [31:0] a;
    int rem, room, b, t, target;
    ar_t ar;
    beat_t bt;
    a = addr; rem = len + 1;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 8;
      b = (rem < room) ? rem : room;
      ar.addr = a; ar.len = 8'(b - 1);
      exp_ar.push_back(ar);
      a = a + 32'(b * 8);
      rem -= b;
    end
    for (int i = 0; i <= len; i++) begin
      bt.data = mem_word(addr + 32'(i * 8));
      bt.last = (i == len);
      bt.err  = bt.last && (eb >= 0 || bl >= 0);
      exp_rd.push_back(bt);
    end
    target = rx_cnt + len + 1;
    ar_stall = stall; err_beat = eb; badlast_beat = bl; sl_beat = 0;
    t = 0;
    while (!req_ready && t < 2000) begin @(negedge clk); t++; end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = addr; req_len = 8'(len);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ar_valid_t1", 64'(ar_valid), 64'd1);
    if (abort) begin
      t = 0;
      while (rx_cnt < target - len + 1 && t < 2000) begin @(negedge clk); t++; end
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ar_valid", 64'(ar_valid), 64'd0);
      chk("rst_r_ready", 64'(r_ready), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      exp_rd.delete(); exp_ar.delete();
      rx_cnt = target;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", 64'(req_ready), 64'd1);
    end else begin
      t = 0;
      while (rx_cnt < target && t < 4000) begin @(negedge clk); t++; end
      chk("rx_count", 64'(rx_cnt), 64'(target));
      chk("ar_left", 64'(exp_ar.size()), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] addr, off;
    int len, eb, bl;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_ar_valid", 64'(ar_valid), 64'd0);
    chk("reset_r_ready", 64'(r_ready), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_last", 64'(rd_last), 64'd0);
    chk("reset_rd_err", 64'(rd_err), 64'd0);
    chk("reset_rd_data", rd_data, 64'd0);
    chk("reset_ar_addr", 64'(ar_addr), 64'd0);
    chk("reset_ar_len", 64'(ar_len), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_req(32'h8000_0000, 3,   0, -1, -1, 1'b0);
    run_req(32'h8000_0FF0, 3,   0, -1, -1, 1'b0);
    run_req(32'h8000_0800, 255, 0, -1, -1, 1'b0);
    run_req(32'h8000_0808, 255, 0, -1, -1, 1'b0);
    run_req(32'h8000_0000, 3,   5, -1, -1, 1'b0);
    run_req(32'h8000_0000, 3,   0,  1, -1, 1'b0);
    run_req(32'h8000_0000, 3,   0, -1,  2, 1'b0);
    run_req(32'h8000_0000, 3,   0, -1, -1, 1'b1);
    run_req(32'h8000_0100, 0,   0, -1, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) off = 32'(4096 - 8 * $urandom_range(1, 40));
      else off = 32'(8 * $urandom_range(0, 511));
      addr = 32'h8000_0000 + 32'($urandom_range(0, 3) * 4096) + off;
      len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
      eb   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
      bl   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
      run_req(addr, len, $urandom_range(0, 3), eb, bl, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_rd_master.md
# axi_rd_master

AXI4 read-burst initiator for the core-side memory path: it turns a simple request (start address, beat count) into one or more INCR read bursts and streams the returned beats out. It is the initiator counterpart of `axi_slave_mem` and connects directly to that model's `ar_*`/`r_*` ports in testbenches. It also serves as the read engine for the SoC's DMA/loader path. It keeps one request in flight and splits any request that crosses a 4 KB boundary.

## Interface
- `AXI_ADDR_WIDTH`, 32, address width
- `AXI_DATA_WIDTH`, 64, data width; BYTES = AXI_DATA_WIDTH/8
- `AXI_ID`, 4'd0, constant ID driven on `ar_id` (`AXI_ID_WIDTH` = 4)
- `clk` in 1: clock. One clock; every register is on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request valid
- `req_ready` out 1: request accepted when `req_valid & req_ready`
- `req_addr` in AXI_ADDR_WIDTH: start byte address, BYTES-aligned
- `req_len` in 8: beats−1 (1..256 beats)
- `rd_valid` out 1: one returned beat, no backpressure
- `rd_data` out AXI_DATA_WIDTH: beat data
- `rd_last` out 1: last beat of the whole request
- `rd_err` out 1: valid with `rd_last`; set if any beat had non-OKAY `r_resp` or an `r_last` mismatch
- `ar_valid` out 1, `ar_ready` in 1: AR handshake
- `ar_addr` out AXI_ADDR_WIDTH: burst start address
- `ar_id` out 4: constant AXI_ID
- `ar_len` out 8: burst beats−1
- `ar_size` out 3: constant log2(BYTES)
- `ar_burst` out 2: constant 2'b01 (INCR)
- `r_valid` in 1, `r_ready` out 1: R handshake
- `r_data` in AXI_DATA_WIDTH: read data
- `r_resp` in 2: response
- `r_last` in 1: last beat of the burst

## Operation
- The FSM has three states: IDLE, ADDR and DATA.
- In IDLE, `req_ready` = 1. On acceptance, latch `cur_addr` = `req_addr`, set `remain` (9-bit) = `req_len` + 1 and clear `err`, then go to ADDR.
- Entering ADDR, register the burst:
  - `bound` = (4096 − `cur_addr`[11:0]) / BYTES
  - `beats` = min(`remain`, `bound`)
  - `ar_addr` = `cur_addr`, `ar_len` = `beats` − 1
- In ADDR, `ar_valid` = 1 with address and length held stable until `ar_ready`; then go to DATA with `bcnt` = `beats`.
- In DATA, `r_ready` = 1. On each `r_valid`:
  - decrement `remain` and `bcnt`
  - `cur_addr` += BYTES
  - `err` |= (`r_resp` != OKAY)
- `bcnt` is authoritative. If `r_last` is asserted on a beat other than `bcnt` == 1, or is missing on that beat, set `err`; termination still follows `bcnt`.
- When `bcnt` reaches 0: if `remain` == 0, go to IDLE; otherwise go to ADDR for the next split burst.
- `r_id` is not checked; only one transaction is ever outstanding.

## Timing
- Reset values:
  - `req_ready` = 1 (state is IDLE)
  - `rd_valid`, `rd_last`, `rd_err`, `ar_valid`, `r_ready` = 0
  - `rd_data`, `ar_addr`, `ar_len` = 0
  - `ar_id`, `ar_size`, `ar_burst` are constants
- Request accepted at cycle T → `ar_valid` high at T+1.
- `rd_valid`, `rd_data`, `rd_last` and `rd_err` are registered: each one pulses the cycle after its R handshake.
- `rd_last` and `rd_err` pulse for exactly one cycle, and only with the final beat of the request.
- Back-to-back requests: the state is IDLE in the cycle `rd_last` is high, so a new request can be accepted in that cycle.
- Between split bursts there is one idle cycle on AR (DATA → ADDR → `ar_valid`).
- A request ending exactly at a 4 KB boundary is not split.
- Reset asserted mid-operation abandons the transfer and forces all outputs to their reset values immediately. The attached slave must be reset together with this block.

## Structure
- The shared package `axi_pkg` holds:
  - `AXI_BURST_INCR`, `AXI_RESP_OKAY`, `AXI_RESP_SLVERR`, `AXI_RESP_DECERR`
  - the `rd_state_e` enum (IDLE/ADDR/DATA)
  - the function `beats_to_4k(addr, bytes)`
- Single module; no sub-module is needed.

## Test plan
- Addr 0x8000_0000, len 3, slave OKAY with data 0x11…, 0x22…, 0x33…, 0x44… → one AR with `ar_addr` 0x8000_0000, `ar_len` 3, `ar_size` 3, `ar_burst` 1; four `rd_valid` pulses in order; `rd_last` on the 4th; `rd_err` 0.
- Addr 0x8000_0FF0, len 3 → AR 0x8000_0FF0 with `ar_len` 1, then AR 0x8000_1000 with `ar_len` 1; `rd_last` only on beat 4.
- Addr 0x8000_0800, len 255 → single burst, `ar_len` 255. Addr 0x8000_0808, len 255 → two bursts: `ar_len` 254 at 0x8000_0808, then `ar_len` 0 at 0x8000_1000.
- `ar_ready` held low for 5 cycles → `ar_valid`, `ar_addr` and `ar_len` stay constant; `r_ready` stays 0 until AR completes.
- Beat 2 of 4 returns `r_resp` = 2'b10 → all 4 beats are delivered; `rd_err` = 1 with `rd_last`. Slave asserts `r_last` on beat 3 of 4 → `rd_err` = 1.
- `rst_n` pulsed low after 2 of 4 beats → `ar_valid` and `r_ready` drop at once; `req_ready` = 1 after release; the next request (addr 0x8000_0100, len 0) completes normally.
